tmds_decoder_align: RTL
=======================

Name: tmds_decoder_align

Overview:
- Receive-side counterpart of the DVI/HDMI TMDS encoder/serializer path: one block per TMDS channel.
- Takes unaligned 10-bit parallel words from a vendor deserializer in the pixel clock domain.
- Finds the word boundary by hunting for control-token runs and locks onto it.
- Decodes each aligned word to 8-bit video data or 2-bit control data plus a data-enable, for the capture/sink logic of the video subsystem.

Parameters:
- lock_count, 8: consecutive identical-offset control tokens required to declare lock.
- search_timeout, 1024: cycles without any control token before the offset advances (SEARCH) or lock is dropped (LOCKED); must exceed frame_x (800).
- offset_bits, 4: width of the offset register (holds 0..9).

Ports:
- clk_pixel  in  1  pixel clock, 25 MHz; the deserializer word clock.
- rstn  in  1  reset, asynchronous, active-low.
- tmds_raw  in  10  deserialized word; bit 0 is the earliest-received bit; boundary arbitrary.
- realign  in  1  synchronous pulse: drop lock, restart search at the current offset + 1.
- data  out  8  decoded video byte; 0 when de=0.
- cd  out  2  decoded control bits {vsync,hsync} on the blue channel; held while de=1.
- de  out  1  1 = data valid (video word), 0 = control period or not locked.
- locked  out  1  word alignment established.
- offset  out  4  current bit offset 0..9.

Behaviour:
- Input pipeline:
  - raw_q <= tmds_raw and raw_qq <= raw_q every cycle.
  - cat = {raw_q, raw_qq} (20 bits).
  - aligned = cat[offset+9 : offset], combinational 10:1 select.
- Control tokens: 0x354 (cd=00), 0x0AB (cd=01), 0x154 (cd=10), 0x2AB (cd=11).
  - is_ctl = aligned matches any token.
- Data decode:
  - d = aligned[9] ? ~aligned[7:0] : aligned[7:0].
  - data[0] = d[0].
  - For i=1..7: data[i] = d[i]^d[i-1] if aligned[8]=1, else ~(d[i]^d[i-1]).
- Outputs are registered. A word fully present in tmds_raw at edge N appears on data/cd/de after edge N+2. Fixed latency 2 cycles.
- State machine, states SEARCH, LOCKED; run_cnt counts consecutive tokens, idle_cnt counts cycles since the last token:
  - SEARCH:
    - is_ctl: run_cnt++ and idle_cnt=0.
    - Otherwise: run_cnt=0 and idle_cnt++.
    - run_cnt reaching lock_count: go to LOCKED, locked=1 on the next edge.
    - idle_cnt reaching search_timeout-1: offset = (offset==9) ? 0 : offset+1, and both counters cleared.
  - LOCKED:
    - is_ctl: idle_cnt=0.
    - Otherwise: idle_cnt++.
    - idle_cnt reaching search_timeout-1: go to SEARCH, locked=0, offset advances by 1 mod 10.
- realign=1 in any state: go to SEARCH, counters cleared, offset advances by 1 mod 10, locked=0 on the next edge. realign has priority over the lock transition in the same cycle.
- While not locked: de=0, data=0, cd=00. Decoding is gated by the registered state, so the first decoded word follows the cycle in which locked rises.
- Data words that happen to equal a token value are treated as control; this is intended, because the encoder never emits them in active video.
- Reset (asynchronous, any time, including mid-search or mid-lock):
  - state=SEARCH, offset=0, counters=0, raw_q/raw_qq=0.
  - data=0, cd=00, de=0, locked=0.

Optional Feature:
- TMDS_DISPARITY_CHECK_EN
- Defined:
  - Adds output disp_err (1 bit, reset 0).
  - Tracks a 5-bit signed running disparity of aligned data words.
  - Disparity resets to 0 on any control word.
  - Each data word adds (#ones - #zeros) of its 10 bits.
  - disp_err pulses 1 cycle, aligned with de, when the magnitude exceeds 8 while locked.
- Undefined: port and logic absent; decode behaviour otherwise identical.

Test Plan:
- Encoder-fed stream at bit offset 0: 160 words of 0x354, then video bytes 0x00, 0xFF, 0x5A, 0xA5 -> locked=1 after the 8th token plus 2 cycles. de=1 with data 0x00, 0xFF, 0x5A, 0xA5 in order, each 2 cycles after input.
- Same stream rotated by 7 bits -> offset steps every 1024 idle cycles until offset=7. locked=1, then decoded bytes match the source exactly.
- Lock, then stop tokens (random data) for 1024 cycles -> locked falls to 0 and offset advances by 1. de=0 thereafter.
- Blue channel with hsync/vsync toggling through 0x354/0x0AB/0x154/0x2AB -> cd=00/01/10/11 with de=0, 2-cycle latency.
- realign pulse while locked at offset 9 -> locked=0 and offset=0 the next cycle. Relock after 8 tokens.
- rstn asserted mid-frame while locked -> all outputs 0 immediately. With TMDS_DISPARITY_CHECK_EN, 5 consecutive 0x3FF data words give disp_err=1.

Source files
------------

// File: rtl/tmds_decoder_align.sv
// One TMDS receive channel: finds the word boundary from control-token runs, then decodes 10b words.
// Define TMDS_DISPARITY_CHECK_EN to add the running-disparity monitor output disp_err.
module tmds_decoder_align #(
    parameter int lock_count     = 8,
    parameter int search_timeout = 1024,
    parameter int offset_bits    = 4
) (
    input  logic                   clk_pixel,
    input  logic                   rstn,
    input  logic [9:0]             tmds_raw,
    input  logic                   realign,
    output logic [7:0]             data,
    output logic [1:0]             cd,
    output logic                   de,
    output logic                   locked,
    output logic [offset_bits-1:0] offset
`ifdef TMDS_DISPARITY_CHECK_EN
    ,
    output logic                   disp_err
`endif
);
    localparam int RUN_W  = $clog2(lock_count + 1);
    localparam int IDLE_W = $clog2(search_timeout);

    typedef enum logic {SEARCH, LOCKED} state_t;
    typedef struct packed {
        logic       ctl;
        logic [1:0] cd;
        logic [7:0] data;
    } word_t;

    state_t                 state_q, state_d;
    logic [RUN_W-1:0]       run_q, run_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic [offset_bits-1:0] offset_d, offset_inc;
    logic [9:0]             raw_q, raw_qq, aligned;
    logic [19:0]            cat;
    logic [4:0]             sel;
    logic [7:0]             d;
    logic                   adv;
    word_t                  dw;

    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            raw_q  <= '0;
            raw_qq <= '0;
        end else begin
            raw_q  <= tmds_raw;
            raw_qq <= raw_q;
        end
    end

    // Older word sits in the low half, so bit 0 of cat is the earliest bit on the wire.
    assign cat     = {raw_q, raw_qq};
    assign sel     = 5'(offset);
    assign aligned = cat[sel +: 10];
    assign d       = aligned[9] ? ~aligned[7:0] : aligned[7:0];

    always_comb begin
        dw = '0;
        case (aligned)
            10'h354: begin dw.ctl = 1'b1; dw.cd = 2'b00; end
            10'h0AB: begin dw.ctl = 1'b1; dw.cd = 2'b01; end
            10'h154: begin dw.ctl = 1'b1; dw.cd = 2'b10; end
            10'h2AB: begin dw.ctl = 1'b1; dw.cd = 2'b11; end
            default: begin
                dw.data[0] = d[0];
                for (int i = 1; i < 8; i++)
                    dw.data[i] = aligned[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
            end
        endcase
    end

    assign offset_inc = (offset == offset_bits'(9)) ? '0 : offset + offset_bits'(1);

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        idle_d   = idle_q;
        offset_d = offset;
        adv      = 1'b0;
        if (realign) begin
            state_d = SEARCH;
            run_d   = '0;
            idle_d  = '0;
            adv     = 1'b1;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (dw.ctl) begin
                        idle_d = '0;
                        if (run_q == RUN_W'(lock_count - 1)) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + RUN_W'(1);
                        end
                    end else begin
                        run_d = '0;
                        if (idle_q == IDLE_W'(search_timeout - 1)) begin
                            idle_d = '0;
                            adv    = 1'b1;
                        end else begin
                            idle_d = idle_q + IDLE_W'(1);
                        end
                    end
                end
                default: begin
                    if (dw.ctl) begin
                        idle_d = '0;
                    end else if (idle_q == IDLE_W'(search_timeout - 1)) begin
                        state_d = SEARCH;
                        idle_d  = '0;
                        run_d   = '0;
                        adv     = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            endcase
        end
        if (adv) offset_d = offset_inc;
    end

    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            state_q <= SEARCH;
            run_q   <= '0;
            idle_q  <= '0;
            offset  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            idle_q  <= idle_d;
            offset  <= offset_d;
        end
    end

    assign locked = (state_q == LOCKED);

    // Gated by the registered state: decode starts the cycle after locked rises.
    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            data <= '0;
            cd   <= '0;
            de   <= 1'b0;
        end else if (state_q == LOCKED) begin
            de   <= ~dw.ctl;
            data <= dw.data;
            if (dw.ctl) cd <= dw.cd;
        end else begin
            data <= '0;
            cd   <= '0;
            de   <= 1'b0;
        end
    end

`ifdef TMDS_DISPARITY_CHECK_EN
    logic [3:0]        ones;
    logic signed [5:0] delta, disp_sum;
    logic signed [4:0] disp_q, disp_next;
    logic              mag_err;

    always_comb begin
        ones = '0;
        for (int i = 0; i < 10; i++) ones = ones + 4'(aligned[i]);
    end

    assign delta    = $signed({1'b0, ones, 1'b0}) - 6'sd10;
    assign disp_sum = $signed({disp_q[4], disp_q}) + delta;
    assign mag_err  = (disp_sum > 6'sd8) || (disp_sum < -6'sd8);

    // Saturate rather than wrap so a long unbalanced run keeps reporting.
    always_comb begin
        if (disp_sum > 6'sd15)       disp_next = 5'sd15;
        else if (disp_sum < -6'sd16) disp_next = 5'b10000;
        else                         disp_next = disp_sum[4:0];
    end

    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            disp_q   <= '0;
            disp_err <= 1'b0;
        end else begin
            disp_q   <= dw.ctl ? 5'sd0 : disp_next;
            disp_err <= (state_q == LOCKED) && !dw.ctl && mag_err;
        end
    end
`endif
endmodule
